// File: rtl/esm_if.sv
`default_nettype none
// ============================================================================
//  Module      : esm_if
//  Description : Signal bundle for the ESM instruction-issue block. Carries the
//                offered instruction with its decode side-bands and the issued
//                instruction returned by the block.
//                  master : drives Instr_in / ALUSrc / RegWrite, reads Instr_out
//                  slave  : reads Instr_in / ALUSrc / RegWrite, drives Instr_out
//  Revision    : 1.0  initial release
// ============================================================================
interface esm_if;
    logic [31:0] Instr_in;
    logic        ALUSrc;
    logic        RegWrite;
    logic [31:0] Instr_out;

    modport master (output Instr_in, output ALUSrc, output RegWrite, input Instr_out);
    modport slave  (input Instr_in, input ALUSrc, input RegWrite, output Instr_out);
endinterface
`default_nettype wire

// File: rtl/esm.sv
`default_nettype none
// ============================================================================
//  Module      : esm
//  Description : Out-of-order issue stage. Non-zero instructions are captured
//                into an age-ordered buffer of DEPTH entries; every cycle the
//                oldest entry free of RAW/WAW/WAR hazards (against older
//                buffered entries and against the in-flight scoreboard) is
//                issued on Instr_out. An issued register writer keeps its rd
//                busy for LAT cycles.
//  Ports       : Instr_in  [31:0] in  offered instruction, 0 = bubble
//                ALUSrc          in  1 = immediate operand, rs2 not read
//                RegWrite        in  1 = instruction writes rd
//                clk             in  rising-edge clock
//                rst             in  asynchronous active-low reset
//                Instr_out [31:0] out registered issued instruction, 0 = none
//  Revision    : 1.0  initial release
// ============================================================================
module esm #(
    parameter int DEPTH = 8,
    parameter int LAT   = 3
) (
    input  wire logic [31:0] Instr_in,
    input  wire logic        ALUSrc,
    input  wire logic        RegWrite,
    input  wire logic        clk,
    input  wire logic        rst,
    output logic      [31:0] Instr_out
);

    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam int              c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_BW    = (LAT > 1) ? $clog2(LAT + 1) : 1;
    // A dependent may issue LAT edges after the producer, so the counter is
    // loaded with LAT-1 and readiness is sampled while it is still counting.
    localparam logic [c_BW-1:0] c_LATM1 = c_BW'(LAT - 1);
    localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);

    // ------------------------------------------------------------------
    // State: entries [0 .. r_cnt-1] are valid, index 0 is the oldest.
    // ------------------------------------------------------------------
    logic [31:0]     r_instr [DEPTH];
    logic [DEPTH-1:0] r_alusrc;
    logic [DEPTH-1:0] r_regwr;
    logic [c_CW-1:0] r_cnt;
    logic [c_BW-1:0] r_busy  [32];
    logic [31:0]     r_out;

    logic [4:0]      w_rd    [DEPTH];
    logic [4:0]      w_rs1   [DEPTH];
    logic [4:0]      w_rs2   [DEPTH];
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_ready;
    logic [31:0]     w_busy;
    logic            w_issue;
    logic [c_IW-1:0] w_sel;
    logic [31:0]     w_sel_instr;
    logic            w_sel_wr;
    logic            w_cap;
    logic [c_CW-1:0] w_wpos;
    logic [c_CW-1:0] w_nx_cnt;
    logic [31:0]     w_nx_instr [DEPTH];
    logic [DEPTH-1:0] w_nx_alusrc;
    logic [DEPTH-1:0] w_nx_regwr;

    // Field decode and valid mask
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rd[i]    = r_instr[i][11:7];
            w_rs1[i]   = r_instr[i][19:15];
            w_rs2[i]   = r_instr[i][24:20];
            w_valid[i] = (c_CW'(i) < r_cnt);
        end
    end

    // Scoreboard view; x0 is never busy
    always_comb begin
        w_busy = '0;
        for (int r = 1; r < 32; r++) begin
            w_busy[r] = (r_busy[r] != '0);
        end
    end

    // Hazard evaluation. Older entries are exactly the lower indices, all of
    // which are valid whenever entry i is valid.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = w_valid[i];
            if (w_rs1[i] != 5'd0 && w_busy[w_rs1[i]])
                w_ready[i] = 1'b0;
            if (!r_alusrc[i] && w_rs2[i] != 5'd0 && w_busy[w_rs2[i]])
                w_ready[i] = 1'b0;
            if (r_regwr[i] && w_rd[i] != 5'd0 && w_busy[w_rd[i]])
                w_ready[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                // older writer: RAW on sources, WAW on rd
                if (r_regwr[j] && w_rd[j] != 5'd0) begin
                    if (w_rd[j] == w_rs1[i])
                        w_ready[i] = 1'b0;
                    if (!r_alusrc[i] && w_rd[j] == w_rs2[i])
                        w_ready[i] = 1'b0;
                    if (r_regwr[i] && w_rd[j] == w_rd[i])
                        w_ready[i] = 1'b0;
                end
                // older reader of our destination: WAR
                if (r_regwr[i] && w_rd[i] != 5'd0) begin
                    if (w_rs1[j] == w_rd[i])
                        w_ready[i] = 1'b0;
                    if (!r_alusrc[j] && w_rs2[j] == w_rd[i])
                        w_ready[i] = 1'b0;
                end
            end
        end
    end

    // Oldest-ready priority select (descending loop lets index 0 win)
    always_comb begin
        w_issue = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_issue = 1'b1;
                w_sel   = c_IW'(i);
            end
        end
        w_sel_instr = '0;
        w_sel_wr    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (c_IW'(i) == w_sel) begin
                w_sel_instr = r_instr[i];
                w_sel_wr    = r_regwr[i];
            end
        end
    end

    // Capture: a full buffer still accepts when the same edge frees a slot
    always_comb begin
        w_cap    = (Instr_in != 32'h0) && ((r_cnt != c_FULL) || w_issue);
        w_wpos   = r_cnt - c_CW'(w_issue);
        w_nx_cnt = w_wpos + c_CW'(w_cap);
    end

    // Next buffer contents: close the gap left by the issued entry, then
    // append the captured instruction at the new tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nx_instr[i] = r_instr[i];
        end
        w_nx_alusrc = r_alusrc;
        w_nx_regwr  = r_regwr;
        if (w_issue) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (c_IW'(i) >= w_sel) begin
                    w_nx_instr[i]  = r_instr[i + 1];
                    w_nx_alusrc[i] = r_alusrc[i + 1];
                    w_nx_regwr[i]  = r_regwr[i + 1];
                end
            end
        end
        if (w_cap) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (c_CW'(i) == w_wpos) begin
                    w_nx_instr[i]  = Instr_in;
                    w_nx_alusrc[i] = ALUSrc;
                    w_nx_regwr[i]  = RegWrite;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
            end
            r_alusrc <= '0;
            r_regwr  <= '0;
            r_cnt    <= '0;
            for (int r = 0; r < 32; r++) begin
                r_busy[r] <= '0;
            end
            r_out <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= w_nx_instr[i];
            end
            r_alusrc <= w_nx_alusrc;
            r_regwr  <= w_nx_regwr;
            r_cnt    <= w_nx_cnt;
            for (int r = 1; r < 32; r++) begin
                if (w_issue && w_sel_wr && w_sel_instr[11:7] == 5'(r))
                    r_busy[r] <= c_LATM1;
                else if (r_busy[r] != '0)
                    r_busy[r] <= r_busy[r] - 1'b1;
            end
            r_out <= w_issue ? w_sel_instr : 32'h0;
        end
    end

    assign Instr_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_esm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_esm
//  Description : Self-checking bench for esm. A queue/timestamp reference
//                model predicts Instr_out every edge; directed sequences add
//                fixed expectations. A second instance with a long latency
//                exercises the full-buffer drop case.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_esm;

    localparam int c_DEPTH  = 8;
    localparam int c_LAT    = 3;
    localparam int c_LAT_L  = 12;

    localparam logic [31:0] c_LI7   = 32'h00200393;
    localparam logic [31:0] c_LI8   = 32'h00500413;
    localparam logic [31:0] c_ADD   = 32'h008384B3;
    localparam logic [31:0] c_LI11  = 32'h00000593;
    localparam logic [31:0] c_SUB   = 32'h40740533;
    localparam logic [31:0] c_LOAD  = 32'h00002083;  // lw x1,0(x0)
    localparam logic [31:0] c_LI20  = 32'h00000A13;

    logic        clk;
    logic        rst;
    logic [31:0] long_out;

    esm_if u_if ();

    esm #(.DEPTH(c_DEPTH), .LAT(c_LAT)) u_dut (
        .Instr_in  (u_if.Instr_in),
        .ALUSrc    (u_if.ALUSrc),
        .RegWrite  (u_if.RegWrite),
        .clk       (clk),
        .rst       (rst),
        .Instr_out (u_if.Instr_out)
    );

    esm #(.DEPTH(c_DEPTH), .LAT(c_LAT_L)) u_long (
        .Instr_in  (u_if.Instr_in),
        .ALUSrc    (u_if.ALUSrc),
        .RegWrite  (u_if.RegWrite),
        .clk       (clk),
        .rst       (rst),
        .Instr_out (long_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending instructions in age order plus, per register,
    // the first edge number at which it may be used again.
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] ins;
        bit          als;
        bit          rw;
    } ent_t;

    ent_t mq[$];
    int   rdy_at[32];
    int   edge_n;

    function automatic bit m_ready(int i);
        logic [4:0] rd  = mq[i].ins[11:7];
        logic [4:0] s1  = mq[i].ins[19:15];
        logic [4:0] s2  = mq[i].ins[24:20];
        bit         u2  = !mq[i].als;
        bit         wr  = mq[i].rw && (rd != 5'd0);
        if (s1 != 5'd0 && rdy_at[s1] > edge_n) return 1'b0;
        if (u2 && s2 != 5'd0 && rdy_at[s2] > edge_n) return 1'b0;
        if (wr && rdy_at[rd] > edge_n) return 1'b0;
        for (int j = 0; j < i; j++) begin
            logic [4:0] ord = mq[j].ins[11:7];
            if (mq[j].rw && ord != 5'd0 &&
                (ord == s1 || (u2 && ord == s2) || (wr && ord == rd))) return 1'b0;
            if (wr && (mq[j].ins[19:15] == rd ||
                       (!mq[j].als && mq[j].ins[24:20] == rd))) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input logic [31:0] ins, input bit als, input bit rw,
                              output logic [31:0] exp);
        int pick = -1;
        edge_n++;
        for (int i = 0; i < mq.size(); i++) begin
            if (pick < 0 && m_ready(i)) pick = i;
        end
        exp = 32'h0;
        if (pick >= 0) begin
            exp = mq[pick].ins;
            if (mq[pick].rw && mq[pick].ins[11:7] != 5'd0)
                rdy_at[mq[pick].ins[11:7]] = edge_n + c_LAT;
            mq.delete(pick);
        end
        if (ins != 32'h0 && mq.size() < c_DEPTH) begin
            ent_t e;
            e.ins = ins; e.als = als; e.rw = rw;
            mq.push_back(e);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        for (int r = 0; r < 32; r++) rdy_at[r] = 0;
        edge_n = 0;
    endtask

    // Drive one instruction, clock one edge, compare against the model
    task automatic step(input logic [31:0] ins, input bit als, input bit rw);
        logic [31:0] exp;
        u_if.Instr_in = ins;
        u_if.ALUSrc   = als;
        u_if.RegWrite = rw;
        @(posedge clk);
        #1;
        model_edge(ins, als, rw, exp);
        check("model", u_if.Instr_out, exp);
    endtask

    // Called 1 time unit after a rising edge; releases away from any edge
    task automatic do_reset();
        u_if.Instr_in = c_LI7;   // must not be captured while in reset
        u_if.ALUSrc   = 1'b1;
        u_if.RegWrite = 1'b1;
        rst = 1'b0;
        #1;
        check("rst_async", u_if.Instr_out, 32'h0);
        check("rst_async_long", long_out, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", u_if.Instr_out, 32'h0);
        u_if.Instr_in = 32'h0;
        rst = 1'b1;
        model_clear();
    endtask

    function automatic logic [31:0] dep_of_x1(int k);
        return (32'(k) << 7) | (32'd1 << 15) | 32'h13;  // addi xk, x1, 0
    endfunction

    logic [31:0] v_ins;
    int          v_issued;
    logic [31:0] v_exp;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        u_if.Instr_in = 32'h0;
        u_if.ALUSrc   = 1'b0;
        u_if.RegWrite = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 6; i++) begin
            step(32'h0, 1'b0, 1'b0);
            check("idle", u_if.Instr_out, 32'h0);
        end

        // Single issue
        do_reset();
        step(c_LI7, 1'b1, 1'b1);  check("single_e1", u_if.Instr_out, 32'h0);
        step(32'h0, 1'b0, 1'b0);  check("single_e2", u_if.Instr_out, c_LI7);
        step(32'h0, 1'b0, 1'b0);  check("single_e3", u_if.Instr_out, 32'h0);

        // RAW stall
        do_reset();
        step(c_LI7, 1'b1, 1'b1);
        step(c_LI8, 1'b1, 1'b1);  check("raw_e2", u_if.Instr_out, c_LI7);
        step(c_ADD, 1'b0, 1'b1);  check("raw_e3", u_if.Instr_out, c_LI8);
        step(32'h0, 1'b0, 1'b0);  check("raw_e4", u_if.Instr_out, 32'h0);
        step(32'h0, 1'b0, 1'b0);  check("raw_e5", u_if.Instr_out, 32'h0);
        step(32'h0, 1'b0, 1'b0);  check("raw_e6", u_if.Instr_out, c_ADD);

        // Bypass, then ordering of the sub after the add
        do_reset();
        step(c_LI7, 1'b1, 1'b1);
        step(c_LI8, 1'b1, 1'b1);
        step(c_ADD, 1'b0, 1'b1);
        step(c_LI11, 1'b1, 1'b1); check("byp_e4", u_if.Instr_out, 32'h0);
        step(32'h0, 1'b0, 1'b0);  check("byp_e5", u_if.Instr_out, c_LI11);
        step(32'h0, 1'b0, 1'b0);  check("byp_e6", u_if.Instr_out, c_ADD);
        step(c_SUB, 1'b0, 1'b1);  check("ord_e7", u_if.Instr_out, 32'h0);
        step(32'h0, 1'b0, 1'b0);  check("ord_e8", u_if.Instr_out, c_SUB);

        // Full buffer on the long-latency instance: load, DEPTH dependents,
        // one extra offered while full and stalled -> dropped.
        do_reset();
        v_issued = 0;
        for (int e = 1; e <= 2 + c_LAT_L + c_DEPTH + 4; e++) begin
            if (e == 1)                   v_ins = c_LOAD;
            else if (e <= c_DEPTH + 1)    v_ins = dep_of_x1(e);
            else if (e == c_DEPTH + 2)    v_ins = c_LI20;
            else                          v_ins = 32'h0;
            step(v_ins, 1'b1, 1'b1);
            if (e == 2)
                v_exp = c_LOAD;
            else if (e >= 2 + c_LAT_L && e < 2 + c_LAT_L + c_DEPTH)
                v_exp = dep_of_x1(e - c_LAT_L);
            else
                v_exp = 32'h0;
            check("full_long", long_out, v_exp);
            if (long_out != 32'h0) v_issued++;
        end
        check("full_count", 32'(v_issued), 32'(c_DEPTH + 1));

        // Randomized traffic with a mid-run reset
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ri;
            if (i == 700) do_reset();
            if ($urandom_range(0, 3) == 0) begin
                ri = 32'h0;
            end else begin
                ri = 32'h0;
                ri[6:0]   = ($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13;
                ri[11:7]  = 5'($urandom_range(0, 7));
                ri[14:12] = 3'($urandom_range(0, 7));
                ri[19:15] = 5'($urandom_range(0, 7));
                ri[24:20] = 5'($urandom_range(0, 7));
            end
            step(ri, 1'($urandom_range(0, 1)), ($urandom_range(0, 6) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/esm.md
ESM -- requirements
Module: esm

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of instruction-buffer entries.
REQ-002 SHALL have parameter LAT, default 3, execution latency in cycles from issue to result availability.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Instr_in  input  32  RV32 instruction offered this cycle; 32'h0 means no instruction (bubble).
REQ-006 SHALL have port ALUSrc  input  1  1 = second operand is immediate (rs2 unused); 0 = rs2 is read.
REQ-007 SHALL have port RegWrite  input  1  1 = instruction writes rd.
REQ-008 SHALL have port Instr_out  output  32  registered issued instruction; 32'h0 when nothing issues.
REQ-009 SHALL use positional port order Instr_in, ALUSrc, RegWrite, clk, rst, Instr_out.

Function
REQ-010 SHALL decode rd=[11:7], rs1=[19:15], rs2=[24:20]; x0 is never a dependency source or target.
REQ-011 SHALL capture a non-zero Instr_in, with its ALUSrc and RegWrite, into the youngest free buffer slot at each rising edge.
REQ-012 SHALL not capture Instr_in equal to 32'h0; ALUSrc and RegWrite are then ignored.
REQ-013 SHALL keep buffer entries in arrival (age) order.
REQ-014 SHALL evaluate each valid entry as ready only when all of the following hold:
  - rs1 and rs2 (rs2 only if ALUSrc=0) are not busy in the scoreboard;
  - rs1 and rs2 are not the rd of any older unissued entry with RegWrite=1 (RAW);
  - if RegWrite=1: rd is not busy, not the rd of an older RegWrite entry (WAW), and not a source of any older unissued entry (WAR).
REQ-015 SHALL, at each rising edge, issue the oldest ready entry: load it into Instr_out, remove it, and close the gap so age order is preserved.
REQ-016 SHALL drive Instr_out=32'h0 after any edge where no entry is ready or the buffer is empty.
REQ-017 SHALL make a captured instruction issue-eligible no earlier than the edge after capture; minimum in-to-out latency is 1 cycle.
REQ-018 SHALL, when an instruction with RegWrite=1 and rd!=0 issues at edge k, mark rd busy so dependents issue no earlier than edge k+LAT.
REQ-019 SHALL allow at most one issue and one capture per edge, both on the same edge.
REQ-020 SHALL, when full, accept the incoming instruction only if an issue frees a slot on that edge; otherwise the incoming instruction is dropped.
REQ-021 SHALL allow a younger independent instruction to issue ahead of a stalled older one.

Reset
REQ-022 SHALL, while rst=0, asynchronously clear all buffer entries, clear all scoreboard busy state, and force Instr_out=32'h0.
REQ-023 SHALL discard in-flight and buffered instructions on reset mid-operation; the first capture occurs on the first rising edge after rst returns high.

Verification
REQ-024 SHALL pass after reset with Instr_in=0: Instr_out stays 32'h0 every cycle.
REQ-025 SHALL pass a single-issue test: capture 32'h00200393 (li x7) at edge 1 -> Instr_out=32'h00200393 after edge 2, 32'h0 after edge 3.
REQ-026 SHALL pass a RAW-stall test: capture at successive edges 1,2,3:
  - 32'h00200393 at edge 1;
  - 32'h00500413 (li x8) at edge 2;
  - 32'h008384B3 (add x9,x7,x8) at edge 3.
  Required response: issues at edges 2, 3 and 6, with 0 on Instr_out at edges 4-5.
REQ-027 SHALL pass a bypass test: the REQ-026 sequence plus 32'h00000593 (li x11) captured at edge 4 -> li x11 issues at edge 5, before the add.
REQ-028 SHALL pass an ordering test: after the add, capture sub x10,x8,x7 (32'h407404B3 with rd=10, i.e. 32'h40740533) -> it issues no earlier than the edge after the add and never before it.
REQ-029 SHALL pass a full-buffer test: fill with DEPTH instructions that all depend on a just-issued load, then offer one more -> it is dropped, and Instr_out later shows exactly DEPTH+1 issues, including the load.
